// File: rtl/tensor_slice_c_drain.sv
// Drain stage for the 8x8 tensor slice: buffers emitted C rows in a small FIFO and writes
// them to output BRAM at base_addr + k*stride, flagging rows lost to FIFO overflow.
module tensor_slice_c_drain #(
    parameter int unsigned DWIDTH            = 16,
    parameter int unsigned MAT_MUL_SIZE      = 8,
    parameter int unsigned AWIDTH            = 10,
    parameter int unsigned ADDR_STRIDE_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH        = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [AWIDTH-1:0]              base_addr,
    input  logic [ADDR_STRIDE_WIDTH-1:0]   addr_stride,
    input  logic [MAT_MUL_SIZE*DWIDTH-1:0] c_data_in,
    input  logic                           c_data_available,
    input  logic                           bram_ready,
    output logic                           bram_we,
    output logic [AWIDTH-1:0]              bram_addr,
    output logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_wdata,
    output logic                           busy,
    output logic                           done,
    output logic                           overflow
);

    localparam int unsigned RW = MAT_MUL_SIZE * DWIDTH;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(MAT_MUL_SIZE + 1);
    localparam logic [CW-1:0] LastRow = CW'(MAT_MUL_SIZE - 1);
    localparam logic [PW:0]   FullCnt = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StCollect, StFlush, StDone} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       captured_q;
    logic [AWIDTH-1:0]   addr_acc_q;
    logic [AWIDTH-1:0]   stride_q;
    logic                overflow_q;
    logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [PW:0]         count_q;
    logic [RW-1:0]       mem_data [FIFO_DEPTH];
    logic [AWIDTH-1:0]   mem_addr [FIFO_DEPTH];

    logic accept_start, capture, pop, full, push, drop;

    if (ADDR_STRIDE_WIDTH > AWIDTH) begin : g_stride_trunc
        logic unused_stride_hi;
        assign unused_stride_hi = ^addr_stride[ADDR_STRIDE_WIDTH-1:AWIDTH];
    end

    always_comb begin
        accept_start = (state_q == StIdle) && start;
        capture      = (state_q == StCollect) && c_data_available;
        pop          = (count_q != '0) && bram_ready;
        full         = (count_q == FullCnt);
        // A full FIFO still accepts the row when the head leaves in the same cycle.
        push         = capture && (!full || pop);
        drop         = capture && full && !pop;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (start) state_d = StCollect;
            StCollect: if (capture && captured_q == LastRow) state_d = StFlush;
            StFlush:   if (count_q == '0 || (pop && count_q == (PW + 1)'(1))) state_d = StDone;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            captured_q <= '0;
            addr_acc_q <= '0;
            stride_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept_start) begin
                captured_q <= '0;
                addr_acc_q <= base_addr;
                stride_q   <= addr_stride[AWIDTH-1:0];
                overflow_q <= 1'b0;
            end else if (capture) begin
                // Dropped rows still consume their address slot.
                captured_q <= captured_q + 1'b1;
                addr_acc_q <= addr_acc_q + stride_q;
                if (drop) overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_data[i] <= '0;
                mem_addr[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_data[wr_ptr_q] <= c_data_in;
                mem_addr[wr_ptr_q] <= addr_acc_q;
                wr_ptr_q           <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (!push && pop) count_q <= count_q - 1'b1;
        end
    end

    always_comb begin
        bram_we    = (count_q != '0);
        bram_addr  = mem_addr[rd_ptr_q];
        bram_wdata = mem_data[rd_ptr_q];
        busy       = (state_q != StIdle);
        done       = (state_q == StDone);
        overflow   = overflow_q;
    end

endmodule

// File: tb/tb_tensor_slice_c_drain.sv
// Scoreboard bench for tensor_slice_c_drain: expected BRAM writes are queued by the stimulus
// and consumed by a monitor on every completed write handshake.
module tb_tensor_slice_c_drain;

    localparam int RW = 128;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [9:0]      base_addr;
    logic [15:0]     addr_stride;
    logic [RW-1:0]   c_data_in;
    logic            c_data_available;
    logic            bram_ready;
    logic            bram_we;
    logic [9:0]      bram_addr;
    logic [RW-1:0]   bram_wdata;
    logic            busy;
    logic            done;
    logic            overflow;

    typedef struct {
        logic [9:0]    addr;
        logic [RW-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    tensor_slice_c_drain dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .base_addr        (base_addr),
        .addr_stride      (addr_stride),
        .c_data_in        (c_data_in),
        .c_data_available (c_data_available),
        .bram_ready       (bram_ready),
        .bram_we          (bram_we),
        .bram_addr        (bram_addr),
        .bram_wdata       (bram_wdata),
        .busy             (busy),
        .done             (done),
        .overflow         (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [RW-1:0] row_val(input int tag, input int k);
        logic [RW-1:0] v;
        for (int i = 0; i < 8; i++) v[i*16 +: 16] = 16'(tag * 16 + k + 1);
        return v;
    endfunction

    // Monitor: pops the scoreboard on each completed write, checks hold-stable and done timing.
    logic            prev_write = 1'b0;
    logic            prev_done  = 1'b0;
    logic            prev_stall = 1'b0;
    logic [9:0]      stall_addr;
    logic [RW-1:0]   stall_data;

    always @(negedge clk) begin
        if (reset) begin
            prev_write = 1'b0;
            prev_done  = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && bram_we) begin
                checks++;
                if (bram_addr !== stall_addr || bram_wdata !== stall_data) begin
                    errors++;
                    $display("FAIL stall_hold: got %0h/%0h expected %0h/%0h",
                             bram_addr, bram_wdata, stall_addr, stall_data);
                end
            end
            if (done) begin
                checks++;
                if (!prev_write || prev_done) begin
                    errors++;
                    $display("FAIL done_timing: got prev_write=%0b prev_done=%0b expected 1/0",
                             prev_write, prev_done);
                end
            end
            if (bram_we && bram_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                             bram_addr, bram_wdata);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    if (bram_addr !== e.addr || bram_wdata !== e.data) begin
                        errors++;
                        $display("FAIL write: got %0h/%0h expected %0h/%0h",
                                 bram_addr, bram_wdata, e.addr, e.data);
                    end
                end
            end
            prev_write = bram_we && bram_ready;
            prev_done  = done;
            prev_stall = bram_we && !bram_ready;
            stall_addr = bram_addr;
            stall_data = bram_wdata;
        end
    end

    // Rows are driven in cycles 0..7 after start; ready is low in [stall_from, +stall_len).
    task automatic run_tile(input logic [9:0] base, input logic [15:0] stride, input int tag,
                            input int stall_from, input int stall_len, input logic [7:0] keep,
                            input logic ovf_exp, input int done_exp, input bit poke);
        int done_at;
        for (int k = 0; k < 8; k++) begin
            if (keep[k]) begin
                wr_t e;
                e.addr = 10'(int'(base) + k * int'(stride));
                e.data = row_val(tag, k);
                exp_q.push_back(e);
            end
        end
        start       = 1'b1;
        base_addr   = base;
        addr_stride = stride;
        tick();
        start = 1'b0;
        check("busy_after_start", RW'(busy), RW'(1));
        check("overflow_cleared", RW'(overflow), RW'(0));
        done_at = -1;
        for (int c = 0; c < 40; c++) begin
            if (c == 1) check("first_write_latency", RW'(bram_we), RW'(1));
            if (done) begin
                done_at = c;
                break;
            end
            c_data_available = (c < 8);
            c_data_in        = (c < 8) ? row_val(tag, c) : '0;
            bram_ready       = !(c >= stall_from && c < stall_from + stall_len);
            start            = poke && (c == 3);
            if (poke && c == 3) base_addr = 10'h2AA;
            tick();
        end
        c_data_available = 1'b0;
        bram_ready       = 1'b1;
        start            = 1'b0;
        check("done_cycle", RW'(done_at), RW'(done_exp));
        check("overflow_end", RW'(overflow), RW'(ovf_exp));
        check("scoreboard_empty", RW'(exp_q.size()), RW'(0));
        tick();
        check("done_pulse_end", RW'(done), RW'(0));
        check("idle_after_done", RW'(busy), RW'(0));
    endtask

    initial begin
        reset            = 1'b1;
        start            = 1'b0;
        base_addr        = '0;
        addr_stride      = '0;
        c_data_in        = '0;
        c_data_available = 1'b0;
        bram_ready       = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // 1: reset values, data pulses in IDLE are ignored
        check("rst_we", RW'(bram_we), RW'(0));
        check("rst_addr", RW'(bram_addr), RW'(0));
        check("rst_wdata", bram_wdata, '0);
        check("rst_busy", RW'(busy), RW'(0));
        check("rst_done", RW'(done), RW'(0));
        check("rst_overflow", RW'(overflow), RW'(0));
        for (int i = 0; i < 3; i++) begin
            c_data_available = 1'b1;
            c_data_in        = row_val(9, i);
            tick();
            check("idle_no_we", RW'(bram_we), RW'(0));
        end
        c_data_available = 1'b0;
        tick();
        check("idle_overflow", RW'(overflow), RW'(0));

        // 2: back-to-back rows, ready always high
        run_tile(10'h010, 16'd2, 0, 100, 0, 8'hFF, 1'b0, 9, 1'b0);

        // 3: long stall drops row 5; remaining rows keep their slots
        run_tile(10'h040, 16'd4, 1, 2, 4, 8'b1101_1111, 1'b1, 12, 1'b0);

        // 4: address wrap mod 1024, overflow cleared by the new start
        run_tile(10'h3FC, 16'd3, 2, 100, 0, 8'hFF, 1'b0, 9, 1'b0);

        // 5: FIFO full with simultaneous pop/push, start during COLLECT ignored
        run_tile(10'h080, 16'd1, 3, 2, 3, 8'hFF, 1'b0, 12, 1'b1);

        // 6: reset mid-tile after three writes
        for (int k = 0; k < 3; k++) begin
            wr_t e;
            e.addr = 10'(12'h100 + k);
            e.data = row_val(5, k);
            exp_q.push_back(e);
        end
        start       = 1'b1;
        base_addr   = 10'h100;
        addr_stride = 16'd1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            c_data_available = 1'b1;
            c_data_in        = row_val(5, c);
            bram_ready       = 1'b1;
            tick();
        end
        reset = 1'b1;
        #1;
        check("midrst_we", RW'(bram_we), RW'(0));
        check("midrst_busy", RW'(busy), RW'(0));
        check("midrst_wdata", bram_wdata, '0);
        check("midrst_writes_seen", RW'(exp_q.size()), RW'(0));
        exp_q.delete();
        tick();
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            c_data_available = 1'b1;
            c_data_in        = row_val(6, c);
            tick();
        end
        c_data_available = 1'b0;
        check("post_rst_we", RW'(bram_we), RW'(0));
        check("post_rst_busy", RW'(busy), RW'(0));
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
